// File: rtl/order_pkg.sv
// order_pkg -- shared definitions for the order issuer slice.
//   ID_W_DEF      default ID width (NUM_ID = 2**ID_W)
//   PAYLOAD_W_DEF default request payload width
//   LAT_W_DEF     default retire-latency field width
//   id_state_e    per-ID lifecycle state
package order_pkg;

  localparam int ID_W_DEF      = 3;
  localparam int PAYLOAD_W_DEF = 16;
  localparam int LAT_W_DEF     = 4;

  // Lifecycle of one ID: FREE -> ISSUED -> TIMING -> PEND -> RETIRED -> FREE
  typedef enum logic [2:0] {
    ST_FREE    = 3'd0,
    ST_ISSUED  = 3'd1,
    ST_TIMING  = 3'd2,
    ST_PEND    = 3'd3,
    ST_RETIRED = 3'd4
  } id_state_e;

endpackage

// File: rtl/order_issuer_if.sv
// order_issuer_if -- request / issue / retire / done signal bundle.
//   master : upstream + ordering-block side (drives *_i, observes *_o)
//   slave  : order_issuer side
//   req_*  : upstream request handshake (valid/ready, payload, order, latency)
//   rx_*   : issue port (valid/ready, id, payload, order) and retire pulse/id
//   done_* : ordering TX completion for an ID
//   busy_o : per-ID in-use vector, err_o : sticky protocol error
interface order_issuer_if #(
  parameter int ID_W      = 3,
  parameter int PAYLOAD_W = 16,
  parameter int LAT_W     = 4
);
  localparam int NUM_ID = 2**ID_W;

  logic                 req_valid_i;
  logic [PAYLOAD_W-1:0] req_payload_i;
  logic                 req_order_i;
  logic [LAT_W-1:0]     req_lat_i;
  logic                 req_ready_o;

  logic                 rx_valid_o;
  logic [ID_W-1:0]      rx_id_o;
  logic [PAYLOAD_W-1:0] rx_payload_o;
  logic                 rx_order_o;
  logic                 rx_ready_i;

  logic                 rx_ret_o;
  logic [ID_W-1:0]      rx_ret_id_o;

  logic                 done_valid_i;
  logic [ID_W-1:0]      done_id_i;

  logic [NUM_ID-1:0]    busy_o;
  logic                 err_o;

  modport master (
    output req_valid_i, req_payload_i, req_order_i, req_lat_i,
    output rx_ready_i, done_valid_i, done_id_i,
    input  req_ready_o, rx_valid_o, rx_id_o, rx_payload_o, rx_order_o,
    input  rx_ret_o, rx_ret_id_o, busy_o, err_o
  );

  modport slave (
    input  req_valid_i, req_payload_i, req_order_i, req_lat_i,
    input  rx_ready_i, done_valid_i, done_id_i,
    output req_ready_o, rx_valid_o, rx_id_o, rx_payload_o, rx_order_o,
    output rx_ret_o, rx_ret_id_o, busy_o, err_o
  );
endinterface

// File: rtl/order_id_entry.sv
// order_id_entry -- lifecycle FSM and retire-latency counter for one ID.
//   clk, reset : clock, async active-high reset
//   alloc      : this ID chosen by the allocator (FREE -> ISSUED)
//   issue_hs   : issue handshake for this ID completed this cycle
//   lat        : latency captured with the request, valid with issue_hs
//   ret_sel    : retire arbiter picked this ID (PEND -> RETIRED)
//   done       : done reported for this ID (RETIRED -> FREE)
//   free/pend/retired : state decodes for the top-level logic
module order_id_entry
  import order_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             issue_hs,
  input  logic [LAT_W-1:0] lat,
  input  logic             ret_sel,
  input  logic             done,
  output logic             free,
  output logic             pend,
  output logic             retired
);

  id_state_e        state;
  logic [LAT_W-1:0] cnt;

  // The handshake cycle itself is the first latency cycle: an ID becomes
  // PEND exactly lat+1 cycles after its handshake. For lat 0 that leaves
  // no cycle to dwell in TIMING, so the entry lands in PEND directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FREE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_FREE:    if (alloc) state <= ST_ISSUED;
        ST_ISSUED: begin
          if (issue_hs) begin
            if (lat == '0) begin
              state <= ST_PEND;
              cnt   <= '0;
            end else begin
              state <= ST_TIMING;
              cnt   <= lat - 1'b1;
            end
          end
        end
        ST_TIMING: begin
          // Counter stops at zero; it never wraps.
          if (cnt == '0) state <= ST_PEND;
          else           cnt   <= cnt - 1'b1;
        end
        ST_PEND:    if (ret_sel) state <= ST_RETIRED;
        ST_RETIRED: if (done)    state <= ST_FREE;
        default:    state <= ST_FREE;
      endcase
    end
  end

  assign free    = (state == ST_FREE);
  assign pend    = (state == ST_PEND);
  assign retired = (state == ST_RETIRED);

endmodule

// File: rtl/order_issuer.sv
// order_issuer -- allocates IDs to upstream requests, issues them to the
// ordering block, times each ID's retire latency and retires one PEND ID
// per cycle (lowest number first). IDs are recycled on done.
//   clk, reset : clock, async active-high reset
//   bus        : order_issuer_if.slave (request, issue, retire, done,
//                busy vector, sticky error)
module order_issuer
  import order_pkg::*;
#(
  parameter int ID_W      = ID_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int LAT_W     = LAT_W_DEF
) (
  input logic           clk,
  input logic           reset,
  order_issuer_if.slave bus
);

  localparam int NUM_ID = 2**ID_W;

  logic [NUM_ID-1:0]    free, pend, retired;
  logic [NUM_ID-1:0]    alloc_vec, hs_vec, ret_vec, done_vec;
  logic                 any_free, pend_any, req_ready, accept, issue_hs;
  logic [ID_W-1:0]      alloc_id, ret_id;

  // Issue register
  logic                 rx_valid;
  logic [ID_W-1:0]      rx_id;
  logic [PAYLOAD_W-1:0] rx_payload;
  logic                 rx_order;
  logic [LAT_W-1:0]     rx_lat;

  // Retire register and error flag
  logic                 rx_ret;
  logic [ID_W-1:0]      rx_ret_id;
  logic                 err;

  // Lowest-numbered FREE ID and lowest-numbered PEND ID.
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_ID-1; i >= 0; i--)
      if (free[i]) alloc_id = ID_W'(i);
  end

  always_comb begin
    ret_id = '0;
    for (int i = NUM_ID-1; i >= 0; i--)
      if (pend[i]) ret_id = ID_W'(i);
  end

  assign any_free = |free;
  assign pend_any = |pend;

  // Ready depends only on registered state and the downstream ready, so
  // upstream never sees a path from its own valid.
  assign req_ready = any_free & (~rx_valid | bus.rx_ready_i);
  assign accept    = bus.req_valid_i & req_ready;
  assign issue_hs  = rx_valid & bus.rx_ready_i;

  assign alloc_vec = accept         ? (NUM_ID'(1) << alloc_id)      : '0;
  assign hs_vec    = issue_hs       ? (NUM_ID'(1) << rx_id)         : '0;
  assign ret_vec   = pend_any       ? (NUM_ID'(1) << ret_id)        : '0;
  assign done_vec  = bus.done_valid_i ? (NUM_ID'(1) << bus.done_id_i) : '0;

  for (genvar g = 0; g < NUM_ID; g++) begin : g_id
    order_id_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .reset    (reset),
      .alloc    (alloc_vec[g]),
      .issue_hs (hs_vec[g]),
      .lat      (rx_lat),
      .ret_sel  (ret_vec[g]),
      .done     (done_vec[g]),
      .free     (free[g]),
      .pend     (pend[g]),
      .retired  (retired[g])
    );
  end

  // A new accept may coincide with the handshake of the previous issue,
  // which keeps back-to-back issue running at one per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_id      <= '0;
      rx_payload <= '0;
      rx_order   <= 1'b0;
      rx_lat     <= '0;
    end else if (accept) begin
      rx_valid   <= 1'b1;
      rx_id      <= alloc_id;
      rx_payload <= bus.req_payload_i;
      rx_order   <= bus.req_order_i;
      rx_lat     <= bus.req_lat_i;
    end else if (issue_hs) begin
      rx_valid   <= 1'b0;
    end
  end

  // Retire pulse: one cycle per selected PEND ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ret    <= 1'b0;
      rx_ret_id <= '0;
    end else begin
      rx_ret <= pend_any;
      if (pend_any) rx_ret_id <= ret_id;
    end
  end

  // Done for an ID that is not RETIRED is a protocol error; sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (bus.done_valid_i & ~retired[bus.done_id_i]) err <= 1'b1;
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rx_valid_o   = rx_valid;
  assign bus.rx_id_o      = rx_id;
  assign bus.rx_payload_o = rx_payload;
  assign bus.rx_order_o   = rx_order;
  assign bus.rx_ret_o     = rx_ret;
  assign bus.rx_ret_id_o  = rx_ret_id;
  assign bus.busy_o       = ~free;
  assign bus.err_o        = err;

endmodule

// File: tb/tb_order_issuer.sv
// tb_order_issuer -- directed + random bench for order_issuer, checked
// against a cycle-level reference model that tracks, per ID, whether it is
// in use, the cycle at which it becomes eligible to retire, and whether it
// has retired.
module tb_order_issuer;

  localparam int ID_W = 3;
  localparam int PW   = 16;
  localparam int LW   = 4;
  localparam int N    = 2**ID_W;
  localparam int INF  = 1 << 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  order_issuer_if #(.ID_W(ID_W), .PAYLOAD_W(PW), .LAT_W(LW)) bus ();

  order_issuer #(.ID_W(ID_W), .PAYLOAD_W(PW), .LAT_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model
  bit          m_busy [N];
  int          m_pend_at [N];
  bit          m_retired [N];
  bit          m_rx_valid;
  logic [ID_W-1:0] m_rx_id;
  logic [PW-1:0]   m_rx_payload;
  bit          m_rx_order;
  int          m_rx_lat;
  bit          m_ret;
  logic [ID_W-1:0] m_ret_id;
  bit          m_err;
  bit          m_acc;
  int          ret_cycle [N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_pend_at[i] = INF; m_retired[i] = 0;
    end
    m_rx_valid = 0; m_rx_id = '0; m_rx_payload = '0; m_rx_order = 0; m_rx_lat = 0;
    m_ret = 0; m_ret_id = '0; m_err = 0; m_acc = 0;
  endtask

  function automatic bit model_ready();
    bit any_free = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) any_free = 1;
    return any_free && (!m_rx_valid || bus.rx_ready_i);
  endfunction

  task automatic compare();
    logic [N-1:0] eb;
    for (int i = 0; i < N; i++) eb[i] = m_busy[i];
    chk("rx_valid",   bus.rx_valid_o,   m_rx_valid);
    chk("rx_id",      bus.rx_id_o,      m_rx_id);
    chk("rx_payload", bus.rx_payload_o, m_rx_payload);
    chk("rx_order",   bus.rx_order_o,   m_rx_order);
    chk("rx_ret",     bus.rx_ret_o,     m_ret);
    if (m_ret) chk("rx_ret_id", bus.rx_ret_id_o, m_ret_id);
    chk("busy",       bus.busy_o,       eb);
    chk("err",        bus.err_o,        m_err);
    chk("req_ready",  bus.req_ready_o,  model_ready());
    if (bus.rx_ret_o === 1'b1) ret_cycle[bus.rx_ret_id_o] = t;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  a = -1;
    int  r = -1;
    bit  rdy = model_ready();
    bit  hs  = m_rx_valid && bus.rx_ready_i;
    bit  dn_ok;
    for (int i = 0; i < N; i++) if (!m_busy[i] && a < 0) a = i;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_retired[i] && m_pend_at[i] <= t && r < 0) r = i;
    dn_ok = bus.done_valid_i && m_busy[bus.done_id_i] && m_retired[bus.done_id_i];
    m_acc = bus.req_valid_i && rdy;

    if (bus.done_valid_i && !dn_ok) m_err = 1;
    if (dn_ok) m_busy[bus.done_id_i] = 0;
    m_ret = (r >= 0);
    if (r >= 0) begin
      m_retired[r] = 1;
      m_ret_id = ID_W'(r);
    end
    // Eligible to retire lat+1 cycles after the handshake.
    if (hs) m_pend_at[m_rx_id] = t + m_rx_lat + 1;
    if (m_acc) begin
      m_busy[a] = 1; m_retired[a] = 0; m_pend_at[a] = INF;
      m_rx_valid = 1; m_rx_id = ID_W'(a);
      m_rx_payload = bus.req_payload_i; m_rx_order = bus.req_order_i;
      m_rx_lat = int'(bus.req_lat_i);
    end else if (hs) begin
      m_rx_valid = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    compare();
    model_step();
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    bus.req_valid_i = 0; bus.done_valid_i = 0; bus.rx_ready_i = 0;
    model_reset();
    #1;
    compare();
    chk("reset_ret_id", bus.rx_ret_id_o, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(logic [PW-1:0] p, logic o, logic [LW-1:0] l);
    bit got = 0;
    bus.req_valid_i = 1; bus.req_payload_i = p; bus.req_order_i = o; bus.req_lat_i = l;
    for (int k = 0; k < 64 && !got; k++) begin
      tick();
      got = m_acc;
    end
    bus.req_valid_i = 0;
    chk("issue_accepted", {31'd0, got}, 1);
  endtask

  task automatic done(int id);
    bus.done_valid_i = 1; bus.done_id_i = ID_W'(id);
    tick();
    bus.done_valid_i = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta;
    int lats [6] = '{15, 15, 5, 15, 15, 2};
    bit pending;

    bus.req_valid_i = 0; bus.req_payload_i = '0; bus.req_order_i = 0; bus.req_lat_i = '0;
    bus.rx_ready_i = 0; bus.done_valid_i = 0; bus.done_id_i = '0;
    for (int i = 0; i < N; i++) ret_cycle[i] = -1;
    @(negedge clk);
    do_reset();

    // Single request, latency 0: issue next cycle, retire two cycles later.
    bus.rx_ready_i = 1;
    ta = t;
    issue(16'h1234, 1'b0, 4'd0);
    repeat (5) tick();
    chk("single_ret_cycle", ret_cycle[0], ta + 3);
    done(0);
    tick();
    chk("single_busy_clear", bus.busy_o, 0);

    // Fill all IDs; the ninth request waits until a done frees ID 4.
    for (int k = 0; k < N; k++) issue(16'($urandom), 1'($urandom), 4'($urandom_range(0, 3)));
    bus.req_valid_i = 1; bus.req_payload_i = 16'hBEEF; bus.req_order_i = 0; bus.req_lat_i = 4'd1;
    repeat (30) tick();
    chk("full_busy", bus.busy_o, 8'hFF);
    chk("full_ready", bus.req_ready_o, 0);
    done(4);
    tick();
    chk("ninth_id", bus.rx_id_o, 4);
    chk("ninth_payload", bus.rx_payload_o, 16'hBEEF);
    bus.req_valid_i = 0;
    repeat (25) tick();
    for (int i = 0; i < N; i++) done(i);
    tick();
    chk("drain_busy", bus.busy_o, 0);

    do_reset();

    // IDs 2 and 5 become eligible together; done to ID 3 while timing.
    bus.rx_ready_i = 1;
    for (int i = 0; i < N; i++) ret_cycle[i] = -1;
    for (int k = 0; k < 6; k++) issue(16'(k * 16'h1111), 1'b1, LW'(lats[k]));
    done(3);
    chk("err_set", bus.err_o, 1);
    repeat (30) tick();
    chk("err_sticky", bus.err_o, 1);
    chk("ret_2_before_5", ret_cycle[5] - ret_cycle[2], 1);
    chk("id3_retired", {31'd0, ret_cycle[3] >= 0}, 1);

    // Downstream stall: issue register held, upstream blocked.
    bus.rx_ready_i = 0;
    issue(16'hA5A5, 1'b1, 4'd1);
    bus.req_valid_i = 1; bus.req_payload_i = 16'h5A5A; bus.req_order_i = 0; bus.req_lat_i = 4'd0;
    repeat (5) tick();
    chk("stall_ready", bus.req_ready_o, 0);
    chk("stall_payload", bus.rx_payload_o, 16'hA5A5);
    bus.rx_ready_i = 1;
    tick();
    bus.req_valid_i = 0;
    repeat (10) tick();

    do_reset();

    // Reset while four IDs are timing: nothing retires afterwards.
    bus.rx_ready_i = 1;
    for (int k = 0; k < 4; k++) issue(16'($urandom), 1'b0, 4'd15);
    repeat (3) tick();
    do_reset();
    chk("post_reset_busy", bus.busy_o, 0);
    repeat (25) tick();

    // Random traffic.
    pending = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && ($urandom_range(0, 1) == 1)) begin
        pending = 1;
        bus.req_payload_i = 16'($urandom);
        bus.req_order_i   = 1'($urandom);
        bus.req_lat_i     = 4'($urandom);
      end
      bus.req_valid_i = pending;
      bus.rx_ready_i  = ($urandom_range(0, 3) != 0);
      bus.done_valid_i = 0;
      if ($urandom_range(0, 2) == 0) begin
        int id = $urandom_range(0, N - 1);
        if (m_busy[id] && m_retired[id]) begin
          bus.done_valid_i = 1;
          bus.done_id_i = ID_W'(id);
        end
      end
      tick();
      if (m_acc) pending = 0;
    end
    bus.req_valid_i = 0; bus.done_valid_i = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/order_issuer.md
ORDER_ISSUER -- requirements
Module: order_issuer

Interface
REQ-001 Parameter ID_W, default 3, ID width; NUM_ID = 2**ID_W IDs.
REQ-002 Parameter PAYLOAD_W, default 16, payload width.
REQ-003 Parameter LAT_W, default 4, retire-latency field width.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  upstream request valid.
REQ-007 req_payload_i  input  PAYLOAD_W  request payload.
REQ-008 req_order_i  input  1  request must be ordered behind all older outstanding requests.
REQ-009 req_lat_i  input  LAT_W  cycles from issue handshake to retire.
REQ-010 req_ready_o  output  1  upstream request accepted when high with req_valid_i.
REQ-011 rx_valid_o / rx_id_o[ID_W] / rx_payload_o[PAYLOAD_W] / rx_order_o  output  issue port to ordering block.
REQ-012 rx_ready_i  input  1  ordering block accepts issue.
REQ-013 rx_ret_o  output  1  retire pulse; rx_ret_id_o  output  ID_W  retired ID.
REQ-014 done_valid_i  input  1, done_id_i  input  ID_W  ordering TX handshake completed for that ID.
REQ-015 busy_o  output  NUM_ID  per-ID in-use vector (state != FREE).
REQ-016 err_o  output  1  sticky protocol error.

Function
REQ-017 Per-ID state: FREE -> ISSUED -> TIMING -> PEND -> RETIRED -> FREE; no other transitions.
REQ-018 req_ready_o = (any ID FREE) & (~rx_valid_o | rx_ready_i), purely from registered state and rx_ready_i.
REQ-019 On req_valid_i & req_ready_o: lowest-numbered FREE ID goes ISSUED; issue register loads ID, payload, order; rx_valid_o high the next cycle.
REQ-020 rx_* outputs held stable while rx_valid_o & ~rx_ready_i; back-to-back issue every cycle sustained when rx_ready_i high.
REQ-021 On rx_valid_o & rx_ready_i: that ID goes TIMING, counter loaded with req_lat_i captured at acceptance.
REQ-022 TIMING counter decrements each cycle; at count 0 the ID goes PEND the following cycle; lat=0 gives PEND one cycle after issue handshake; lat=15 gives PEND 16 cycles after.
REQ-023 Retire arbiter: each cycle, lowest-numbered PEND ID selected; that ID goes RETIRED; rx_ret_o and rx_ret_id_o registered, high exactly one cycle per retire; max one retire per cycle.
REQ-024 done_valid_i with done_id_i in RETIRED: ID goes FREE next cycle; allocatable from that cycle, not in the done cycle.
REQ-025 done_valid_i for ID not in RETIRED: ignored for state, err_o set and held until reset.
REQ-026 Full: all IDs non-FREE -> req_ready_o low; request held by upstream.
REQ-027 Simultaneous accept, issue handshake, retire and done on different IDs all take effect in the same cycle.
REQ-028 Counter arithmetic unsigned LAT_W bits, never wraps below 0.

Reset
REQ-029 On reset all IDs FREE, counters 0, rx_valid_o 0, rx_id_o/rx_payload_o/rx_order_o 0, rx_ret_o 0, rx_ret_id_o 0, busy_o 0, err_o 0, req_ready_o 1 after deassertion.
REQ-030 Reset mid-operation discards all outstanding IDs and pending retires; no rx_ret_o pulse after reset assertion.

Structure
REQ-031 Shared package order_pkg holds ID_W, PAYLOAD_W, LAT_W defaults and the per-ID state enum (FREE, ISSUED, TIMING, PEND, RETIRED).
REQ-032 Sub-module order_id_entry implements one ID's state FSM and latency counter; instantiated NUM_ID times; allocation, issue register and retire arbiter live in order_issuer.

Verification
REQ-033 Reset, one request payload 0x1234 lat 0, rx_ready_i=1 -> rx_valid_o cycle 1 with ID 0; rx_ret_o with ID 0 cycle 3; done ID 0 -> busy_o returns 0x00.
REQ-034 Nine requests, rx_ready_i=1, no done -> IDs 0..7 issued, busy_o=0xFF, req_ready_o low for 9th until a done frees an ID, then 9th gets that ID.
REQ-035 rx_ready_i low 5 cycles with rx_valid_o high -> rx_id_o/rx_payload_o constant, req_ready_o low, counter not started.
REQ-036 IDs 2 and 5 reaching PEND same cycle -> rx_ret_o ID 2 in cycle N, ID 5 in cycle N+1.
REQ-037 done_valid_i for ID 3 while ID 3 TIMING -> err_o 1 and sticky, ID 3 still retires normally.
REQ-038 reset asserted with 4 IDs TIMING -> all outputs reset values, no later rx_ret_o pulse.
